// File: rtl/sd_pkg.sv
// Shared definitions for the SD command-line engine.
//   - resp_type encodings, engine state enum
//   - CRC7 generator polynomial (x^7 + x^3 + 1) and its single-bit step
//   - command / response token lengths
package sd_pkg;

  typedef enum logic [1:0] {
    RESP_NONE = 2'b00,  // no response expected
    RESP_R1   = 2'b01,  // short 48-bit, CRC checked
    RESP_R2   = 2'b10,  // long 136-bit, CRC checked
    RESP_R3   = 2'b11   // short 48-bit, CRC field ignored
  } resp_type_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX,
    ST_WAIT,
    ST_RX,
    ST_GAP
  } state_e;

  localparam logic [6:0]  CRC7_POLY    = 7'h09;
  localparam int unsigned TOKEN_SHORT  = 48;
  localparam int unsigned TOKEN_LONG   = 136;

  // One bit of CRC7, MSB-first.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc7_serial.sv
// Bit-serial CRC7 register shared by the transmit and receive paths.
// Ports:
//   clk   - bit clock
//   clr   - zero the register (highest priority)
//   en    - fold din into the CRC
//   din   - data bit
//   shift - shift the register left, zero-filled (TX read-out of crc[6])
//   crc   - current CRC value
module sd_crc7_serial
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  input  logic       shift,
  output logic [6:0] crc
);

  always_ff @(posedge clk) begin
    if (clr)
      crc <= '0;
    else if (en)
      crc <= crc7_step(crc, din);
    else if (shift)
      crc <= {crc[5:0], 1'b0};
  end

endmodule

// File: rtl/sd_cmd_engine.sv
// SD CMD-line engine: sends a 48-bit command token with inline CRC7, then
// optionally receives a 48/136-bit response with timeout, framing and CRC
// checks, followed by an Ncc idle gap before signalling done.
// Build option: define SD_CMD_RX_CRC_EN to include the receive CRC check;
// without it err_crc is constant 0 (TX CRC is always generated).
// Ports:
//   clk, reset                 - bit clock, synchronous active-high reset
//   start, cmd_index, cmd_arg  - request and command fields (taken when ready)
//   resp_type                  - 00 none, 01 R1, 10 R2 (136b), 11 R3 (no CRC)
//   ready, done                - idle flag, one-cycle completion pulse
//   resp_data                  - received token, right-aligned, MSB first
//   err_timeout/crc/frame      - status of the last transaction
//   sd_cmd_o, sd_cmd_oe, sd_cmd_i - CMD pad
module sd_cmd_engine
  import sd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned NCC_CYCLES     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [5:0]   cmd_index,
  input  logic [31:0]  cmd_arg,
  input  logic [1:0]   resp_type,
  output logic         ready,
  output logic         done,
  output logic [135:0] resp_data,
  output logic         err_timeout,
  output logic         err_crc,
  output logic         err_frame,
  output logic         sd_cmd_o,
  output logic         sd_cmd_oe,
  input  logic         sd_cmd_i
);

  // The response window counts from the end-bit cycle, so the last WAIT
  // sample is TIMEOUT_CYCLES-2 samples after the first one.
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 2);
  localparam logic [15:0] GAP_LAST  = 16'(NCC_CYCLES - 1);

  state_e     state;
  resp_type_e rtype;
  logic [39:0] tx_sr;     // bits 46..8 of the command token, MSB in [39]
  logic [5:0]  bit_cnt;   // index of the token bit currently on the line
  logic [5:0]  tx_nb;
  logic [7:0]  rx_idx;    // index of the response bit sampled this cycle
  logic [15:0] wait_cnt;
  logic [15:0] gap_cnt;
  logic        tx_bit;

  logic       crc_clr, crc_en, crc_din, crc_shift;
  logic [6:0] crc_val;

  assign tx_nb  = bit_cnt - 6'd1;
  // Before the final shift, token bit k sits at resp_data[k-1].
  assign tx_bit = (rtype == RESP_R2) ? resp_data[133] : resp_data[45];

  sd_crc7_serial u_crc (
    .clk   (clk),
    .clr   (crc_clr),
    .en    (crc_en),
    .din   (crc_din),
    .shift (crc_shift),
    .crc   (crc_val)
  );

`ifdef SD_CMD_RX_CRC_EN
  logic [7:0] crc_top;
  assign crc_top = (rtype == RESP_R2) ? 8'd127 : 8'd46;
`endif

  // The start bit (always 0) leaves a cleared CRC at 0, so clearing at the
  // start bit is equivalent to folding it in.
  always_comb begin
    crc_clr   = reset;
    crc_en    = 1'b0;
    crc_din   = 1'b0;
    crc_shift = 1'b0;
    case (state)
      ST_IDLE: if (start) crc_clr = 1'b1;
      ST_TX: begin
        if (bit_cnt != 6'd0) begin
          if (tx_nb >= 6'd8) begin
            crc_en  = 1'b1;
            crc_din = tx_sr[39];
          end else if (tx_nb != 6'd0) begin
            crc_shift = 1'b1;
          end
        end
      end
      ST_WAIT: if (!sd_cmd_i) crc_clr = 1'b1;
`ifdef SD_CMD_RX_CRC_EN
      ST_RX: begin
        if (rx_idx >= 8'd8 && rx_idx <= crc_top) begin
          crc_en  = 1'b1;
          crc_din = sd_cmd_i;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      rtype       <= RESP_NONE;
      tx_sr       <= '0;
      bit_cnt     <= '0;
      rx_idx      <= '0;
      wait_cnt    <= '0;
      gap_cnt     <= '0;
      ready       <= 1'b1;
      done        <= 1'b0;
      resp_data   <= '0;
      err_timeout <= 1'b0;
      err_frame   <= 1'b0;
      sd_cmd_o    <= 1'b1;
      sd_cmd_oe   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_TX;
            ready       <= 1'b0;
            rtype       <= resp_type_e'(resp_type);
            tx_sr       <= {1'b1, cmd_index, cmd_arg, 1'b0};
            bit_cnt     <= 6'd47;
            sd_cmd_oe   <= 1'b1;
            sd_cmd_o    <= 1'b0;
            resp_data   <= '0;
            err_timeout <= 1'b0;
            err_frame   <= 1'b0;
          end
        end
        ST_TX: begin
          if (bit_cnt == 6'd0) begin
            sd_cmd_oe <= 1'b0;
            sd_cmd_o  <= 1'b1;
            wait_cnt  <= '0;
            gap_cnt   <= '0;
            state     <= (rtype == RESP_NONE) ? ST_GAP : ST_WAIT;
          end else begin
            bit_cnt <= tx_nb;
            if (tx_nb >= 6'd8) begin
              sd_cmd_o <= tx_sr[39];
              tx_sr    <= tx_sr << 1;
            end else if (tx_nb != 6'd0) begin
              sd_cmd_o <= crc_val[6];
            end else begin
              sd_cmd_o <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (!sd_cmd_i) begin
            state     <= ST_RX;
            resp_data <= {resp_data[134:0], 1'b0};
            rx_idx    <= (rtype == RESP_R2) ? 8'd134 : 8'd46;
          end else if (wait_cnt == WAIT_LAST) begin
            err_timeout <= 1'b1;
            state       <= ST_GAP;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        ST_RX: begin
          resp_data <= {resp_data[134:0], sd_cmd_i};
          if (rx_idx == 8'd0) begin
            err_frame <= ~sd_cmd_i | tx_bit;
            state     <= ST_GAP;
          end else begin
            rx_idx <= rx_idx - 8'd1;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= ST_IDLE;
            ready <= 1'b1;
            done  <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SD_CMD_RX_CRC_EN
  logic crc_bad;
  // At the end bit, crc_val covers the protected range and resp_data[6:0]
  // holds the received CRC field (bits 7..1).
  always_ff @(posedge clk) begin
    if (reset)
      crc_bad <= 1'b0;
    else if (state == ST_IDLE && start)
      crc_bad <= 1'b0;
    else if (state == ST_RX && rx_idx == 8'd0)
      crc_bad <= (rtype != RESP_R3) && (crc_val != resp_data[6:0]);
  end
  assign err_crc = crc_bad;
`else
  logic unused_crc_bits;
  assign unused_crc_bits = ^crc_val[5:0];
  assign err_crc = 1'b0;
`endif

endmodule

// File: doc/sd_cmd_engine.md
# sd_cmd_engine

Parametrised SD command-line engine: the single-clock successor of the host's command sender. It serialises a 48-bit host command token with CRC7 generated bit-serially inline, so no separate CRC load/ready phase is needed. It then optionally receives and checks a 48-bit or 136-bit card response on the same line, with timeout and framing checks. It sits between the host command sequencer and the SD CMD pad (tri-state via `sd_cmd_oe`).

## Interface
- `TIMEOUT_CYCLES`, 64: max response-wait cycles (Ncr) before timeout.
- `NCC_CYCLES`, 8: idle cycles, line released high, between end of transaction and `ready`.
- `clk` in 1: SD bit clock; everything is sampled and driven on its rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request; accepted only when `ready`=1.
- `cmd_index` in 6: command index, captured at acceptance.
- `cmd_arg` in 32: argument, captured at acceptance.
- `resp_type` in 2: 00 none, 01 short 48-bit with CRC, 10 long 136-bit (R2), 11 short without CRC (R3).
- `ready` out 1: idle, can accept.
- `done` out 1: one-cycle completion pulse.
- `resp_data` out 136: raw received token, MSB first; short responses right-aligned in [47:0], upper bits 0.
- `err_timeout`, `err_crc`, `err_frame` out 1 each: status of the last transaction.
- `sd_cmd_o` out 1, `sd_cmd_oe` out 1: CMD pad drive.
- `sd_cmd_i` in 1: CMD pad sample.

## Operation
- **IDLE:** `ready`=1, `sd_cmd_oe`=0, `sd_cmd_o`=1. On `start`, latch inputs, clear `resp_data` and error flags, go to TX.
- **TX (48 cycles):** `oe`=1. Token is {0, 1, cmd_index, cmd_arg, crc7, 1}, sent MSB first. CRC7 (x^7+x^3+1, init 0) accumulates over token bits [47:8] as they are sent. Bits [7:1] are shifted out of the CRC register, then the end bit.
- **After TX:**
  - `resp_type`=00: go to GAP.
  - Otherwise: go to WAIT.
- **WAIT:**
  - `oe`=0. Sample `sd_cmd_i` each cycle.
  - First 0 sampled: go to RX; this is token bit 47.
  - `TIMEOUT_CYCLES` consecutive 1s: set `err_timeout`, go to GAP.
- **RX:** shift in 47 (short) or 135 (long) further bits into `resp_data`. CRC7 restarts at the start bit.
  - Short: CRC covers bits [47:8].
  - Long: CRC covers bits [127:8].
  - Either case: compare against bits [7:1].
  - Transmission bit (bit 46 short, bit 134 long) must be 0, and end bit [0] must be 1; otherwise set `err_frame`.
  - CRC mismatch sets `err_crc`, except for type 11, which is never CRC-checked.
- **GAP:** `NCC_CYCLES` cycles with `oe`=0. Then return to IDLE, pulsing `done` for one cycle as `ready` returns to 1.
- `start` while `ready`=0 is ignored.
- `resp_data` and error flags hold until the next accepted `start`.
- **Reset (any state, including mid-TX/RX):** next cycle IDLE, `ready`=1, `done`=0, `sd_cmd_oe`=0, `sd_cmd_o`=1, `resp_data`=0, all error flags 0. `reset` wins over a simultaneous `start`.

## Timing
- `start` accepted at cycle T; token bit 47 appears on `sd_cmd_o` at T+1, end bit at T+48.
- `oe` drops at T+49; the first WAIT sample is taken at T+49.
- No response: `done` and `ready` at T+49+NCC_CYCLES.
- Timeout: `err_timeout` rises at T+48+TIMEOUT_CYCLES and is stable when `done` pulses, NCC_CYCLES later.
- Response start bit sampled at cycle S: last bit at S+47 (short) or S+135 (long); errors valid at S+48/S+136; `done` at S+48+NCC_CYCLES (short).
- Error flags and `resp_data` are valid whenever `done`=1.

## Configuration
- `SD_CMD_RX_CRC_EN` defined: receive-side CRC7 check is implemented as above.
- Undefined: the receive CRC path is removed, `err_crc` is tied 0, and framing and timeout checks remain. TX CRC is always present.

## Structure
- Package `sd_pkg` holds:
  - the resp_type encodings;
  - the state enum (IDLE, TX, WAIT, RX, GAP);
  - CRC7 polynomial constant 7'h09;
  - token lengths 48 and 136.
- One sub-module, `sd_crc7_serial`: clear, enable, data bit in, 7-bit CRC out, plus a shift-out mode for TX. A single instance is shared by TX and RX, since they never overlap.

## Test plan
- CMD0, arg 0, resp 00 -> `sd_cmd_o` = 48'h400000000095 over T+1..T+48; `done` at T+57; no errors.
- CMD8, arg 32'h1AA, resp 01; bench replies 48'h08000001AA13 after 3 cycles -> `sd_cmd_o` = 48'h48000001AA87; `resp_data[47:0]` = reply; no errors.
- CMD55, arg 0, resp 01; no reply -> tx 48'h770000000065; `err_timeout`=1 at T+112; `done` 8 cycles later.
- Resp 01 reply with one CRC bit flipped -> `err_crc`=1 (0 when built without `SD_CMD_RX_CRC_EN`). Same reply with end bit 0 -> `err_frame`=1.
- CMD2, resp 10; bench sends a valid 136-bit R2 -> `resp_data` equals the full token; no errors; `done` at S+144.
- `reset` at T+20 mid-TX -> next cycle `oe`=0, `ready`=1, `sd_cmd_o`=1; a new `start` then runs a clean CMD0.
